// File: rtl/branch_pkg.sv
// branch_pkg
// Shared types and constants for the branch resolution slice.
//   bq_entry_t : one in-flight prediction {pc, hit, pred, target}
//   br_state_t : resolver FSM states (RUN, FLUSH)
//   PC_STEP    : sequential fetch increment used for not-taken redirects
package branch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic        hit;
        logic        pred;
        logic [31:0] target;
    } bq_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } br_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/branch_queue.sv
// branch_queue
// Program-order FIFO of fetch-time predictions.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : enqueue push_data (ignored while full)
//   push_data  : entry to enqueue
//   pop        : drop the head entry (ignored while empty)
//   clear      : discard every entry; wins over push and pop
//   full       : DEPTH entries held (registered)
//   empty      : no entries held (registered)
//   head       : oldest entry, valid while !empty
module branch_queue
    import branch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  bq_entry_t push_data,
    input  logic      pop,
    input  logic      clear,
    output logic      full,
    output logic      empty,
    output bq_entry_t head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    bq_entry_t      mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW:0]    count;
    logic           do_push;
    logic           do_pop;

    // full is judged on the count before this edge, so a push while full
    // is dropped even if a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/branch_resolver.sv
// branch_resolver
// Checks queued fetch predictions against execute's resolution, drives the
// branch target table update port and issues a redirect plus a fixed-length
// flush on a mispredict.
// Optional feature: define BRANCH_STATS_EN to add stat_branches and
// stat_mispredicts (32-bit wrapping counters, cleared by reset).
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   push, push_pc/hit/pred/target      : fetch-time prediction to enqueue
//   full, empty                        : queue occupancy flags
//   res_valid, res_is_branch,
//   res_taken, res_target              : resolution of the oldest entry
//   write_rp, write_rt                 : table prediction / tag+target strobes
//   result_alu, b_dest_in,
//   instruction_update                 : table update data
//   redirect_valid, redirect_pc        : one-cycle fetch redirect
//   flush                              : kill younger in-flight instructions
module branch_resolver
    import branch_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [31:0] push_pc,
    input  logic        push_hit,
    input  logic        push_pred,
    input  logic [31:0] push_target,
    output logic        full,
    output logic        empty,
    input  logic        res_valid,
    input  logic        res_is_branch,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    output logic        write_rp,
    output logic        write_rt,
    output logic        result_alu,
    output logic [31:0] b_dest_in,
    output logic [31:0] instruction_update,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);

    br_state_t     state;
    br_state_t     state_next;
    logic [CW-1:0] flush_cnt;
    logic [CW-1:0] flush_cnt_next;

    bq_entry_t     head;
    bq_entry_t     push_entry;
    logic          do_push;
    logic          do_pop;
    logic          branch_pop;
    logic          ptaken;
    logic          target_differs;
    logic          mispredict;
    logic          need_rt;

    assign push_entry = '{pc: push_pc, hit: push_hit, pred: push_pred, target: push_target};

    // Both push and resolve are frozen outside RUN; the queue gates them
    // further on full/empty.
    assign do_push = push && (state == RUN);
    assign do_pop  = res_valid && !empty && (state == RUN);

    assign branch_pop     = do_pop && res_is_branch;
    assign ptaken         = head.hit & head.pred;
    assign target_differs = (head.target != res_target);
    assign mispredict     = branch_pop &&
                            ((res_taken != ptaken) || (res_taken && ptaken && target_differs));
    assign need_rt        = branch_pop && res_taken && (!head.hit || target_differs);

    // A mispredict clears the queue; the clear also swallows a same-cycle push.
    branch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (do_push),
        .push_data (push_entry),
        .pop       (do_pop),
        .clear     (mispredict),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

    // FSM state register and flush down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    // Next state: FLUSH lasts FLUSH_CYCLES cycles, counting down to zero.
    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        case (state)
            RUN: begin
                if (mispredict) begin
                    state_next     = FLUSH;
                    flush_cnt_next = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (flush_cnt == '0) begin
                    state_next = RUN;
                end else begin
                    flush_cnt_next = flush_cnt - 1'b1;
                end
            end
            default: begin
                state_next     = RUN;
                flush_cnt_next = '0;
            end
        endcase
    end

    // FSM outputs.
    always_comb begin
        flush = (state == FLUSH);
    end

    // Registered update port and redirect. Strobes pulse for one cycle; the
    // data fields hold their last value between branch resolutions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_rp           <= 1'b0;
            write_rt           <= 1'b0;
            result_alu         <= 1'b0;
            b_dest_in          <= '0;
            instruction_update <= '0;
            redirect_valid     <= 1'b0;
            redirect_pc        <= '0;
        end else begin
            write_rp       <= branch_pop;
            write_rt       <= need_rt;
            redirect_valid <= mispredict;
            if (branch_pop) begin
                result_alu         <= res_taken;
                b_dest_in          <= res_target;
                instruction_update <= head.pc;
            end
            if (mispredict) begin
                redirect_pc <= res_taken ? res_target : (head.pc + PC_STEP);
            end
        end
    end

`ifdef BRANCH_STATS_EN
    // Resolution statistics, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (branch_pop) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mispredict) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver
// Directed self-checking bench for branch_resolver (DEPTH=4, FLUSH_CYCLES=2).
module tb_branch_resolver;

    logic        clk;
    logic        rst_n;
    logic        push;
    logic [31:0] push_pc;
    logic        push_hit;
    logic        push_pred;
    logic [31:0] push_target;
    logic        full;
    logic        empty;
    logic        res_valid;
    logic        res_is_branch;
    logic        res_taken;
    logic [31:0] res_target;
    logic        write_rp;
    logic        write_rt;
    logic        result_alu;
    logic [31:0] b_dest_in;
    logic [31:0] instruction_update;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int errors = 0;
    int checks = 0;

    branch_resolver #(
        .DEPTH        (4),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .push               (push),
        .push_pc            (push_pc),
        .push_hit           (push_hit),
        .push_pred          (push_pred),
        .push_target        (push_target),
        .full               (full),
        .empty              (empty),
        .res_valid          (res_valid),
        .res_is_branch      (res_is_branch),
        .res_taken          (res_taken),
        .res_target         (res_target),
        .write_rp           (write_rp),
        .write_rt           (write_rt),
        .result_alu         (result_alu),
        .b_dest_in          (b_dest_in),
        .instruction_update (instruction_update),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .flush              (flush)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches      (stat_branches),
        .stat_mispredicts   (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle so registered outputs can be sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        push          = 1'b0;
        push_pc       = '0;
        push_hit      = 1'b0;
        push_pred     = 1'b0;
        push_target   = '0;
        res_valid     = 1'b0;
        res_is_branch = 1'b0;
        res_taken     = 1'b0;
        res_target    = '0;
    endtask

    task automatic set_push(input logic [31:0] pc, input logic hit, input logic pred,
                            input logic [31:0] tgt);
        push        = 1'b1;
        push_pc     = pc;
        push_hit    = hit;
        push_pred   = pred;
        push_target = tgt;
    endtask

    task automatic set_resolve(input logic is_br, input logic taken, input logic [31:0] tgt);
        res_valid     = 1'b1;
        res_is_branch = is_br;
        res_taken     = taken;
        res_target    = tgt;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b want 0", full); end
        checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL reset_flush: got %b want 0", flush); end
        checks++; if ({write_rp, write_rt, redirect_valid, result_alu} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_strobes: got %b want 0000", {write_rp, write_rt, redirect_valid, result_alu}); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_redirect_pc: got %h want 0", redirect_pc); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_correct_taken();
        set_push(32'h40, 1'b1, 1'b1, 32'h80);
        tick();
        idle_inputs();
        checks++; if (empty !== 1'b0) begin errors++; $display("[TB] FAIL ct_empty_after_push: got %b want 0", empty); end
        set_resolve(1'b1, 1'b1, 32'h80);
        tick();
        idle_inputs();
        checks++; if (write_rp !== 1'b1) begin errors++; $display("[TB] FAIL ct_write_rp: got %b want 1", write_rp); end
        checks++; if (result_alu !== 1'b1) begin errors++; $display("[TB] FAIL ct_result_alu: got %b want 1", result_alu); end
        checks++; if (write_rt !== 1'b0) begin errors++; $display("[TB] FAIL ct_write_rt: got %b want 0", write_rt); end
        checks++; if (instruction_update !== 32'h40) begin errors++; $display("[TB] FAIL ct_instr_update: got %h want 00000040", instruction_update); end
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL ct_redirect: got %b want 0", redirect_valid); end
        checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL ct_flush: got %b want 0", flush); end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL ct_empty_after_pop: got %b want 1", empty); end
        tick();
        checks++; if (write_rp !== 1'b0) begin errors++; $display("[TB] FAIL ct_write_rp_pulse: got %b want 0", write_rp); end
    endtask

    task automatic test_mispredict_taken();
        set_push(32'h44, 1'b0, 1'b0, 32'h0);
        tick();
        set_resolve(1'b1, 1'b1, 32'h100);
        push = 1'b0;
        tick();
        idle_inputs();
        checks++; if (write_rt !== 1'b1) begin errors++; $display("[TB] FAIL mt_write_rt: got %b want 1", write_rt); end
        checks++; if (b_dest_in !== 32'h100) begin errors++; $display("[TB] FAIL mt_b_dest_in: got %h want 00000100", b_dest_in); end
        checks++; if (instruction_update !== 32'h44) begin errors++; $display("[TB] FAIL mt_instr_update: got %h want 00000044", instruction_update); end
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("[TB] FAIL mt_redirect_valid: got %b want 1", redirect_valid); end
        checks++; if (redirect_pc !== 32'h100) begin errors++; $display("[TB] FAIL mt_redirect_pc: got %h want 00000100", redirect_pc); end
        checks++; if (flush !== 1'b1) begin errors++; $display("[TB] FAIL mt_flush_c1: got %b want 1", flush); end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL mt_empty: got %b want 1", empty); end
        tick();
        checks++; if (flush !== 1'b1) begin errors++; $display("[TB] FAIL mt_flush_c2: got %b want 1", flush); end
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL mt_redirect_pulse: got %b want 0", redirect_valid); end
        tick();
        checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL mt_flush_end: got %b want 0", flush); end
    endtask

    task automatic test_mispredict_not_taken();
        set_push(32'h48, 1'b1, 1'b1, 32'h200);
        tick();
        set_resolve(1'b1, 1'b0, 32'h0);
        push = 1'b0;
        tick();
        idle_inputs();
        checks++; if (redirect_pc !== 32'h4C) begin errors++; $display("[TB] FAIL mn_redirect_pc: got %h want 0000004c", redirect_pc); end
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("[TB] FAIL mn_redirect_valid: got %b want 1", redirect_valid); end
        checks++; if (result_alu !== 1'b0) begin errors++; $display("[TB] FAIL mn_result_alu: got %b want 0", result_alu); end
        checks++; if (write_rt !== 1'b0) begin errors++; $display("[TB] FAIL mn_write_rt: got %b want 0", write_rt); end
        checks++; if (write_rp !== 1'b1) begin errors++; $display("[TB] FAIL mn_write_rp: got %b want 1", write_rp); end
        tick();
        tick();
        checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL mn_flush_end: got %b want 0", flush); end
    endtask

    task automatic test_full_drop();
        for (int i = 0; i < 4; i++) begin
            set_push(32'h100 + 32'(4 * i), 1'b1, 1'b1, 32'h300);
            tick();
        end
        checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL fd_full: got %b want 1", full); end
        set_push(32'h110, 1'b1, 1'b1, 32'h300);
        set_resolve(1'b0, 1'b0, 32'h0);
        tick();
        idle_inputs();
        checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL fd_full_after: got %b want 0", full); end
        checks++; if ({write_rp, write_rt, redirect_valid} !== 3'b000) begin errors++; $display("[TB] FAIL fd_no_update: got %b want 000", {write_rp, write_rt, redirect_valid}); end
        // Three remaining entries must come out as 0x104, 0x108, 0x10C.
        for (int i = 1; i < 4; i++) begin
            set_resolve(1'b1, 1'b1, 32'h300);
            tick();
            idle_inputs();
            checks++; if (instruction_update !== 32'h100 + 32'(4 * i)) begin errors++; $display("[TB] FAIL fd_pop_pc%0d: got %h want %h", i, instruction_update, 32'h100 + 32'(4 * i)); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL fd_empty_after_three: got %b want 1", empty); end
    endtask

    task automatic test_flush_ignore();
        set_push(32'h500, 1'b0, 1'b0, 32'h0);
        tick();
        set_resolve(1'b1, 1'b1, 32'h600);
        push = 1'b0;
        tick();
        set_push(32'h700, 1'b1, 1'b1, 32'h800);
        set_resolve(1'b1, 1'b1, 32'h800);
        tick();
        checks++; if (flush !== 1'b1) begin errors++; $display("[TB] FAIL fi_flush: got %b want 1", flush); end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL fi_empty_c1: got %b want 1", empty); end
        checks++; if (write_rp !== 1'b0) begin errors++; $display("[TB] FAIL fi_write_rp: got %b want 0", write_rp); end
        tick();
        idle_inputs();
        checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL fi_flush_end: got %b want 0", flush); end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL fi_empty_exit: got %b want 1", empty); end
        checks++; if (write_rp !== 1'b0) begin errors++; $display("[TB] FAIL fi_write_rp_exit: got %b want 0", write_rp); end
    endtask

    task automatic test_reset_mid_flush();
        set_push(32'h800, 1'b0, 1'b0, 32'h0);
        tick();
        set_resolve(1'b1, 1'b1, 32'h900);
        push = 1'b0;
        tick();
        idle_inputs();
        checks++; if (flush !== 1'b1) begin errors++; $display("[TB] FAIL rf_flush_before: got %b want 1", flush); end
        rst_n = 1'b0;
        #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL rf_flush: got %b want 0", flush); end
        checks++; if ({write_rp, write_rt, redirect_valid, result_alu} !== 4'b0000) begin errors++; $display("[TB] FAIL rf_strobes: got %b want 0000", {write_rp, write_rt, redirect_valid, result_alu}); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("[TB] FAIL rf_redirect_pc: got %h want 0", redirect_pc); end
        checks++; if (b_dest_in !== 32'h0) begin errors++; $display("[TB] FAIL rf_b_dest_in: got %h want 0", b_dest_in); end
        checks++; if (instruction_update !== 32'h0) begin errors++; $display("[TB] FAIL rf_instr_update: got %h want 0", instruction_update); end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL rf_empty: got %b want 1", empty); end
        @(negedge clk);
        rst_n = 1'b1;
        set_push(32'hA00, 1'b1, 1'b0, 32'h0);
        tick();
        idle_inputs();
        checks++; if (empty !== 1'b0) begin errors++; $display("[TB] FAIL rf_push_after: got %b want 0", empty); end
        checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL rf_flush_after: got %b want 0", flush); end
    endtask

    initial begin
        test_reset();
        test_correct_taken();
        test_mispredict_taken();
        test_mispredict_not_taken();
        test_full_drop();
        test_flush_ignore();
        test_reset_mid_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Resolution-side companion to the branch target table. Every fetch-time prediction is queued in program order. When execute resolves the oldest branch, the block checks the prediction against the actual outcome. It then drives the table's update port (prediction bit, tag and target writes) and, on a mispredict, issues a registered fetch redirect followed by a fixed-length pipeline flush.

## Interface
Parameters:
- DEPTH, 4 — in-flight prediction queue entries (power of two, ≥2)
- FLUSH_CYCLES, 2 — cycles `flush` is held after a mispredict (≥1)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- push  input  1  fetch enqueues a prediction
- push_pc  input  32  fetched instruction address
- push_hit  input  1  table tag hit at fetch
- push_pred  input  1  table prediction bit at fetch
- push_target  input  32  table destination at fetch
- full  output  1  queue holds DEPTH entries
- empty  output  1  queue holds 0 entries
- res_valid  input  1  execute resolves the oldest queued instruction
- res_is_branch  input  1  resolved instruction is a branch
- res_taken  input  1  actual branch outcome
- res_target  input  32  actual branch destination
- write_rp  output  1  table prediction-bit write strobe
- write_rt  output  1  table tag/destination write strobe
- result_alu  output  1  new prediction bit
- b_dest_in  output  32  new destination
- instruction_update  output  32  address of the branch being updated
- redirect_valid  output  1  one-cycle fetch redirect
- redirect_pc  output  32  corrected fetch address
- flush  output  1  younger in-flight instructions must be killed

## Operation
- The queue is a FIFO of {pc, hit, pred, target}.
  - Push is accepted when `push && !full && state==RUN`.
  - Pop happens when `res_valid && !empty && state==RUN`.
  - `full` is evaluated before the pop, so a push while full is dropped even if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH.
- `res_valid` is ignored while `empty` or while in FLUSH.
- Effective prediction: `ptaken = hit & pred`.
- A non-branch pop (`res_is_branch=0`) only removes the entry. It produces no update and no redirect.
- A branch pop drives the update port:
  - `write_rp=1`, `result_alu=res_taken`, `instruction_update=pc`, `b_dest_in=res_target`.
  - `write_rt=1` only when `res_taken && (!hit || target!=res_target)`.
- Mispredict condition: `res_taken!=ptaken || (res_taken && ptaken && target!=res_target)`.
- On a mispredict:
  - `redirect_valid=1`; `redirect_pc` is `res_target` if taken, else `pc+4` (32-bit wrap).
  - The queue is cleared, any push in the same cycle is discarded, and the FSM moves RUN→FLUSH.
- FSM states:
  - RUN (reset state): normal push and pop.
  - FLUSH: `flush=1`, push and resolve are ignored, a down-counter loads FLUSH_CYCLES-1; at 0 the FSM returns to RUN.

## Timing
- Update strobes and redirect are registered and pulse for exactly one cycle at T+1 after the resolving `res_valid` edge T.
- `flush` is high on cycles T+1 … T+FLUSH_CYCLES. Push is accepted again at T+FLUSH_CYCLES+1.
- `full` and `empty` reflect the queue state after the current edge; there is no combinational path from `push`.
- Reset values (asynchronous, immediate on rst_n low):
  - All strobes, `result_alu`, `flush`, `redirect_valid`, `full` = 0.
  - `b_dest_in`, `instruction_update`, `redirect_pc` = 0.
  - `empty` = 1; state = RUN; counters = 0.
- Reset asserted mid-flush abandons the flush; the block returns to RUN with an empty queue.

## Configuration
- `BRANCH_STATS_EN` defined adds two output ports, each 32 bits, wrapping, and cleared by reset:
  - `stat_branches`: incremented per resolved branch.
  - `stat_mispredicts`: incremented per mispredict.
- Without the macro these ports and their counters do not exist; all other behaviour is identical.

## Structure
- Shared package `branch_pkg`:
  - Queue entry struct `bq_entry_t` {pc, hit, pred, target}.
  - State enum `br_state_t` {RUN, FLUSH}.
  - Constant `PC_STEP=32'd4`.
- Sub-module `branch_queue`: parameterised FIFO with push, pop, clear, full, empty and head outputs. The FSM, compare logic and update logic stay in the top level.

## Test plan
- Push pc=0x40 (hit=1, pred=1, target=0x80); resolve taken with target 0x80 → T+1: write_rp=1, result_alu=1, write_rt=0; no redirect, no flush.
- Push pc=0x44 (hit=0); resolve taken with target 0x100 → T+1: write_rt=1, b_dest_in=0x100, instruction_update=0x44, redirect_pc=0x100; flush high 2 cycles; queue empty.
- Push pc=0x48 (hit=1, pred=1); resolve not-taken → redirect_pc=0x4C, result_alu=0, write_rt=0.
- Fill 4 entries, then a fifth push while full together with a non-branch pop → fifth push dropped; 3 entries remain; no update strobes.
- Assert push and res_valid during FLUSH → both ignored; entry count unchanged at the flush exit.
- Drop rst_n during FLUSH → all outputs at reset values immediately; after release, the first push is accepted (empty=0 next cycle).
